// File: rtl/x_uart_rx.sv
// x_uart_rx: 8N1 asynchronous serial receiver.
//   Bit period P = p_clk_hz/p_baud + 1 clock cycles, half period H = P/2.
//   The line passes through a 2-flop synchroniser; the start bit is confirmed
//   at mid-bit and every data/stop bit is sampled one full period later.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data[7:0]  received byte (LSB first on the line)
//   o_valid      o_data holds an unconsumed byte
//   i_accept     consumer takes o_data when o_valid & i_accept
//   o_frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   o_overrun    one-cycle pulse: new byte overwrote an unaccepted byte
//
// Build option:
//   X_UART_RX_MAJORITY_EN  each start/data/stop decision is a 2-of-3 vote of
//                          rx_s at s-1, s, s+1, taken at s+1 (one cycle later).

module x_uart_rx #(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_accept,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned P  = (p_clk_hz / p_baud) + 1;
  localparam int unsigned H  = P / 2;
  localparam int unsigned TW = $clog2(P);

  localparam logic [TW-1:0] T_LAST = TW'(P - 1);
`ifdef X_UART_RX_MAJORITY_EN
  // Start decision moves one cycle later; the timer is cleared at the start
  // decision, so every later sample point shifts by the same cycle.
  localparam logic [TW-1:0] T_START = TW'(H);
`else
  localparam logic [TW-1:0] T_START = TW'(H - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_d;
  logic [TW-1:0]   timer, timer_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            rx_meta, rx_s;
  logic            bit_val;
  logic            stop_ok, stop_bad;

  // Two-flop synchroniser, idle-high reset value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef X_UART_RX_MAJORITY_EN
  // hist[0] = rx_s one cycle ago, hist[1] = two cycles ago.
  logic [1:0] hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist <= '1;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_val = rx_s;
`endif

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, timer, shift and completion strobes
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (timer == T_START) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = bit_val ? IDLE : DATA;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      DATA: begin
        if (timer == T_LAST) begin
          timer_d   = '0;
          shift_d   = {bit_val, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      STOP: begin
        if (timer == T_LAST) begin
          timer_d  = '0;
          state_d  = IDLE;
          stop_ok  = bit_val;
          stop_bad = ~bit_val;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      timer       <= timer_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      o_frame_err <= stop_bad;
      o_overrun   <= stop_ok & o_valid & ~i_accept;
      if (stop_ok) begin
        // A completion coinciding with an accept simply replaces the byte.
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (o_valid && i_accept) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_x_uart_rx.sv
// tb_x_uart_rx: self-checking bench for x_uart_rx at default parameters
// (P=105, H=52). Expected bytes go into a scoreboard queue when a frame is
// sent; a monitor pops and compares whenever the receiver loads a byte.

module tb_x_uart_rx;

  localparam int P = (12000000 / 115200) + 1;
`ifdef X_UART_RX_MAJORITY_EN
  localparam int LAT = 2 + (P / 2) + 9 * P + 2;
`else
  localparam int LAT = 2 + (P / 2) + 9 * P + 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       accept;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] sb[$];

  x_uart_rx #(
    .p_clk_hz(12000000),
    .p_baud  (115200)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_accept   (accept),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; drives a full frame with P-cycle bits.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(P);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(P);
    end
    rx = stop_bit;
    wait_cycles(P);
    rx = 1'b1;
  endtask

  // Monitor: a load is a rising o_valid, an overrun overwrite, or o_valid
  // staying high right after a cycle in which it was accepted.
  logic prev_valid = 1'b0;
  logic prev_acc   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (valid && (!prev_valid || prev_acc || overrun)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_load: got data=%0h, scoreboard empty", data);
        end else begin
          check("rx_data", int'(data), int'(sb.pop_front()));
        end
      end
      prev_valid = valid;
      prev_acc   = accept;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       stop_bit;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int f0, o0;

    vecs[0] = '{8'h3C, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b0, 1};
    vecs[2] = '{8'hFF, 1'b1, 0};
    vecs[3] = '{8'h81, 1'b1, 0};
    vecs[4] = '{8'hE7, 1'b1, 0};

    rst_n  = 1'b0;
    rx     = 1'b1;
    accept = 1'b0;
    wait_cycles(3);
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Latency of 0xA5 with accept held high, and a one-cycle o_valid pulse.
    accept = 1'b1;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (!valid && n < 3000) begin
          wait_cycles(1);
          n++;
        end
        check("latency", n, LAT);
        wait_cycles(1);
        check("valid_pulse_width", int'(valid), 0);
      end
    join
    wait_cycles(2 * P);
    check("a5_frame_err", ferr_cnt - f0, 0);
    check("a5_overrun", ovr_cnt - o0, 0);
    check("a5_sb_empty", sb.size(), 0);

    // 20-cycle start glitch: no byte, no error.
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(2 * P);
    check("glitch_valid", int'(valid), 0);
    check("glitch_frame_err", ferr_cnt - f0, 0);

    // Table of frames with accept held high.
    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      if (vecs[i].stop_bit) sb.push_back(vecs[i].d);
      send_frame(vecs[i].d, vecs[i].stop_bit);
      wait_cycles(2 * P);
      check("vec_frame_err", ferr_cnt - f0, vecs[i].exp_ferr);
      check("vec_overrun", ovr_cnt - o0, 0);
      check("vec_sb_empty", sb.size(), 0);
      check("vec_valid_idle", int'(valid), 0);
    end

    // Back-to-back 0x12, 0x34 without accept: overrun overwrite.
    accept = 1'b0;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_cycles(2 * P);
    check("ovr_count", ovr_cnt - o0, 1);
    check("ovr_frame_err", ferr_cnt - f0, 0);
    check("ovr_valid", int'(valid), 1);
    check("ovr_data", int'(data), 8'h34);
    check("ovr_sb_empty", sb.size(), 0);
    accept = 1'b1;
    wait_cycles(1);
    accept = 1'b0;
    check("accept_clears_valid", int'(valid), 0);

    // Accept in the exact completion cycle of a second byte.
    o0 = ovr_cnt;
    sb.push_back(8'h6B);
    send_frame(8'h6B, 1'b1);
    wait_cycles(2 * P);
    check("hold_valid", int'(valid), 1);
    check("hold_data", int'(data), 8'h6B);
    sb.push_back(8'hC4);
    fork
      send_frame(8'hC4, 1'b1);
      begin
        wait_cycles(LAT - 1);
        accept = 1'b1;
        wait_cycles(1);
        accept = 1'b0;
      end
    join
    wait_cycles(2 * P);
    check("coinc_overrun", ovr_cnt - o0, 0);
    check("coinc_valid", int'(valid), 1);
    check("coinc_data", int'(data), 8'hC4);
    check("coinc_sb_empty", sb.size(), 0);

    // Reset pulse during bit 4 of a partial frame.
    rx = 1'b0;
    wait_cycles(P);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_cycles(P);
    end
    rx = 1'b0;
    wait_cycles(P / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(valid), 0);
    check("midrst_data", int'(data), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_overrun", int'(overrun), 0);
    rx = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2 * P);
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    check("post_rst_valid", int'(valid), 0);
    accept = 1'b1;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_cycles(2 * P);
    check("post_rst_sb_empty", sb.size(), 0);
    check("post_rst_frame_err", ferr_cnt - f0, 0);
    check("post_rst_overrun", ovr_cnt - o0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_uart_rx.md
# x_uart_rx

Asynchronous serial receiver, 8N1, the receive-side counterpart of the team's UART transmitter. It shares that transmitter's bit timing: one bit period is P = p_clk_hz/p_baud + 1 clock cycles. It oversamples a synchronised copy of the line, recovers each byte and presents it on a valid/accept handshake. Framing and overrun errors are flagged as single-cycle pulses.

## Interface
- p_clk_hz, 12000000, system clock frequency in Hz
- p_baud, 115200, line rate; integer division p_clk_hz/p_baud must be ≥ 8
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_rx  input  1  serial line, idle high, asynchronous to i_clk
- o_data  output  8  received byte, LSB first on the line
- o_valid  output  1  o_data holds an unconsumed byte
- i_accept  input  1  consumer takes o_data when o_valid & i_accept
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- o_overrun  output  1  one-cycle pulse: new byte overwrote an unaccepted byte

## Operation
- i_rx passes through a 2-flop synchroniser, giving rx_s. Both flops reset to 1.
- Constants: P = p_clk_hz/p_baud + 1 and H = P/2 (integer division). The timer is wide enough to hold P-1 and counts 0..P-1, then wraps.
- States:
  - IDLE: timer held at 0. rx_s==0 moves to START and the timer starts counting.
  - START: at timer==H-1, rx_s==1 is treated as a glitch and returns to IDLE. Otherwise go to DATA, bit index 0, timer cleared.
  - DATA: at each timer==P-1, sample rx_s into a shift register (LSB first) and increment the bit index. After index 7, go to STOP.
  - STOP: at timer==P-1, sample rx_s and return to IDLE. This happens at mid-stop-bit, so a back-to-back start edge is caught.
- Stop sample 1: load o_data, set o_valid.
  - If o_valid was already 1 and i_accept is 0 in that cycle, pulse o_overrun; the new byte overwrites the old one.
- Stop sample 0: pulse o_frame_err. o_data and o_valid are unchanged.
- Handshake:
  - o_valid & i_accept clears o_valid on the next edge.
  - If a completion coincides with an accept, the new byte loads, o_valid stays 1, and there is no overrun.
  - i_accept while o_valid==0 is ignored.
- o_data is stable while o_valid==1, except on an overrun overwrite.

## Timing
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, state IDLE, timer 0, rx_s=1.
- Define t0 as the first cycle rx_s==0 in IDLE. i_rx falls 2 edges before this.
- The start check occurs at t0+H.
- Data bit n is sampled at t0+H+(n+1)·P. The stop bit is sampled at t0+H+9·P.
- o_valid, o_frame_err and o_overrun are registered and become visible on the edge following the stop sample.
- Reset assertion mid-frame immediately returns all state to the reset values. A partial frame is discarded and no pulse is emitted.
- After reset release with i_rx low, reception starts only once rx_s==0 is seen in IDLE. Sampling then proceeds normally, so a line held low produces a frame error.

## Configuration
- X_UART_RX_MAJORITY_EN defined:
  - Each start, data and stop decision is a 2-of-3 majority of rx_s at sample points s-1, s, s+1, where s is the nominal point above.
  - The decision is taken at s+1, so every sample time and o_valid shift one cycle later.
- X_UART_RX_MAJORITY_EN undefined: a single sample at s. No vote registers are present.

## Test plan
Default parameters (P=105, H=52). Serial stimulus is driven with P-cycle bits.
- 0xA5, 8N1, i_accept held 1 → o_valid pulses for 1 cycle with o_data=0xA5. This occurs 2+52+9·105+1 cycles after the i_rx fall (one more with MAJORITY_EN). No error pulses.
- i_rx low for 20 cycles then high → returns to IDLE at the start check. No o_valid, no error. A following 0x3C is received correctly.
- 0x00 with stop bit driven 0 → o_frame_err pulses once; o_valid stays 0. The next frame, 0xFF, is received.
- Two back-to-back frames 0x12 then 0x34 with i_accept=0 → o_valid=1 with 0x12, then o_overrun pulses and o_data=0x34. Asserting i_accept then clears o_valid next cycle.
- i_accept asserted in the exact completion cycle of a second byte → o_valid remains 1 with the new byte, and o_overrun stays 0.
- i_rst_n pulsed low during bit 4 of a frame → all outputs 0 immediately. The next full frame, 0x5A, is received correctly.
